// File: rtl/fetch_unit.sv
// fetch_fifo: flushable in-order buffer of fixed-width records; head is a registered read.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the caller never pushes when full or pops when empty; flush wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       core_clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop_vld) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_vld && !pop_vld) begin
                count_d = count_q + CNT_ONE;
            end else if (!push_vld && pop_vld) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge core_clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// fetch_unit: PC generator issuing sequential word fetches, buffering {pc, instr} toward decode.
// Latency: a response in cycle N is at the decode head in N+1; a redirect in N requests the target in N+1.
// Backpressure: a buffer slot is reserved per request, so issue stalls when buffered + in-flight hits depth.
module fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BUFFER_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  fetch_unit_clock_in,
    input  logic                  fetch_unit_reset_in,
    output logic                  fetch_unit_mem_req_valid_out,
    output logic [DATA_WIDTH-1:0] fetch_unit_mem_req_addr_out,
    input  logic                  fetch_unit_mem_req_ready_in,
    input  logic                  fetch_unit_mem_rsp_valid_in,
    input  logic [31:0]           fetch_unit_mem_rsp_data_in,
    input  logic                  fetch_unit_redirect_valid_in,
    input  logic [DATA_WIDTH-1:0] fetch_unit_redirect_addr_in,
    output logic                  fetch_unit_ins_valid_out,
    output logic [31:0]           fetch_unit_ins_data_out,
    output logic [DATA_WIDTH-1:0] fetch_unit_ins_pc_out,
    input  logic                  fetch_unit_ins_ready_in
);
    localparam int CNT_W  = $clog2(BUFFER_DEPTH) + 1;
    localparam int FIFO_W = DATA_WIDTH + 32;
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = 4;
    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);
    localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
    localparam logic [CNT_W:0]        SLOT_CAP  = (CNT_W + 1)'(BUFFER_DEPTH);

    logic                  clk;
    logic                  rst;
    logic                  redir_vld;
    logic                  rsp_vld;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      drop_q, drop_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [FIFO_W-1:0]     fifo_head;
    logic [CNT_W:0]        slots_used;
    logic [CNT_W-1:0]      rsp_dec;
    logic [DATA_WIDTH-1:0] redir_pc;
    logic                  req_vld;
    logic                  req_fire;
    logic                  drop_pending;
    logic                  push_vld;
    logic                  ins_vld;
    logic                  pop_vld;

    assign clk       = fetch_unit_clock_in;
    assign rst       = fetch_unit_reset_in;
    assign redir_vld = fetch_unit_redirect_valid_in;
    assign rsp_vld   = fetch_unit_mem_rsp_valid_in;

    assign slots_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_vld      = !rst && !redir_vld && (slots_used < SLOT_CAP);
    assign req_fire     = req_vld && fetch_unit_mem_req_ready_in;
    assign drop_pending = (drop_q != '0);
    assign push_vld     = rsp_vld && !drop_pending && !redir_vld;
    assign ins_vld      = (fifo_count != '0);
    assign pop_vld      = ins_vld && fetch_unit_ins_ready_in && !redir_vld;
    assign rsp_dec      = rsp_vld ? CNT_ONE : '0;
    assign redir_pc     = fetch_unit_redirect_addr_in & WORD_MASK;

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q - rsp_dec;
        if (redir_vld) begin
            // Everything still in flight belongs to the abandoned path.
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = outstanding_q - rsp_dec;
        end else begin
            if (req_fire) begin
                pc_d          = pc_q + PC_STEP;
                outstanding_d = outstanding_q + CNT_ONE - rsp_dec;
            end
            if (rsp_vld) begin
                if (drop_pending) begin
                    drop_d = drop_q - CNT_ONE;
                end else begin
                    rsp_pc_d = rsp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (BUFFER_DEPTH)
    ) u_buf (
        .core_clk (clk),
        .rst      (rst),
        .flush    (redir_vld),
        .push_vld (push_vld),
        .push_dat ({rsp_pc_q, fetch_unit_mem_rsp_data_in}),
        .pop_vld  (pop_vld),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    assign fetch_unit_mem_req_valid_out = req_vld;
    assign fetch_unit_mem_req_addr_out  = pc_q;
    assign fetch_unit_ins_valid_out     = ins_vld;
    assign fetch_unit_ins_data_out      = ins_vld ? fifo_head[31:0] : 32'h0;
    assign fetch_unit_ins_pc_out        = ins_vld ? fifo_head[FIFO_W-1:32] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed tables, hand-built redirect/reset sequences and random traffic
// against a queue-based model of the memory and of the expected instruction stream.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_vld, req_rdy, rsp_vld, redir_vld, ins_vld, ins_rdy;
    logic [31:0] req_addr, rsp_dat, redir_addr, ins_dat, ins_pc;

    logic        v64, r64, iv64;
    logic [63:0] a64, ipc64;
    logic [31:0] idat64;
    logic        z1 = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic [63:0] z64 = 64'h0;

    fetch_unit #(.DATA_WIDTH(32), .BUFFER_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .fetch_unit_clock_in          (clk),
        .fetch_unit_reset_in          (rst),
        .fetch_unit_mem_req_valid_out (req_vld),
        .fetch_unit_mem_req_addr_out  (req_addr),
        .fetch_unit_mem_req_ready_in  (req_rdy),
        .fetch_unit_mem_rsp_valid_in  (rsp_vld),
        .fetch_unit_mem_rsp_data_in   (rsp_dat),
        .fetch_unit_redirect_valid_in (redir_vld),
        .fetch_unit_redirect_addr_in  (redir_addr),
        .fetch_unit_ins_valid_out     (ins_vld),
        .fetch_unit_ins_data_out      (ins_dat),
        .fetch_unit_ins_pc_out        (ins_pc),
        .fetch_unit_ins_ready_in      (ins_rdy)
    );

    fetch_unit #(.DATA_WIDTH(64), .BUFFER_DEPTH(DEPTH), .RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
        .fetch_unit_clock_in          (clk),
        .fetch_unit_reset_in          (rst),
        .fetch_unit_mem_req_valid_out (v64),
        .fetch_unit_mem_req_addr_out  (a64),
        .fetch_unit_mem_req_ready_in  (r64),
        .fetch_unit_mem_rsp_valid_in  (z1),
        .fetch_unit_mem_rsp_data_in   (z32),
        .fetch_unit_redirect_valid_in (z1),
        .fetch_unit_redirect_addr_in  (z64),
        .fetch_unit_ins_valid_out     (iv64),
        .fetch_unit_ins_data_out      (idat64),
        .fetch_unit_ins_pc_out        (ipc64),
        .fetch_unit_ins_ready_in      (z1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: memory returns word_of(addr) lat cycles after acceptance; words requested
    // before the latest redirect/reset (older epoch) must never reach decode.
    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    mreq_t       memq[$];
    logic [31:0] bufq[$];
    logic [31:0] m_pc;
    int epoch = 0, cyc = 0, lat = 1, drops = 0, fires = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt,
                        output bit o_req, output logic [31:0] o_addr,
                        output bit o_ins, output logic [31:0] o_pc);
        bit    e_req, rsp;
        mreq_t e;
        req_rdy    = rdy;
        ins_rdy    = irdy;
        redir_vld  = redir;
        redir_addr = tgt;
        rsp        = (memq.size() > 0) && (memq[0].due <= cyc);
        rsp_vld    = rsp;
        rsp_dat    = rsp ? word_of(memq[0].addr) : 32'h0;
        #1;
        e_req = !redir && (bufq.size() + memq.size() < DEPTH);
        chk("req_valid", req_vld, e_req);
        if (e_req) chk("req_addr", req_addr, m_pc);
        chk("ins_valid", ins_vld, bufq.size() > 0);
        chk("ins_pc", ins_pc, (bufq.size() > 0) ? bufq[0] : 32'h0);
        chk("ins_data", ins_dat, (bufq.size() > 0) ? word_of(bufq[0]) : 32'h0);
        o_req  = req_vld;
        o_addr = req_addr;
        o_ins  = ins_vld;
        o_pc   = ins_pc;
        @(posedge clk);
        if (bufq.size() > 0 && irdy && !redir) void'(bufq.pop_front());
        if (rsp) begin
            e = memq.pop_front();
            if (!redir && e.epoch == epoch) bufq.push_back(e.addr);
            else drops++;
        end
        if (redir) begin
            bufq.delete();
            epoch++;
            m_pc = tgt & ~32'h3;
        end else if (e_req && rdy) begin
            memq.push_back('{addr: m_pc, epoch: epoch, due: cyc + lat});
            m_pc += 32'h4;
            fires++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
        bit          a, c;
        logic [31:0] b, d;
        tick(rdy, irdy, redir, tgt, a, b, c, d);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_rdy = 0; ins_rdy = 0; redir_vld = 0; redir_addr = 0;
        rsp_vld = 0; rsp_dat = 0; r64 = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", req_vld, 0);
        chk("rst_ins_valid", ins_vld, 0);
        chk("rst_ins_data", ins_dat, 0);
        chk("rst_ins_pc", ins_pc, 0);
        chk("rst64_req_valid", v64, 0);
        chk("rst64_ins_pc", ipc64, 0);
        memq.delete();
        bufq.delete();
        epoch++;
        m_pc  = RV;
        fires = 0;
        rst   = 1'b0;
    endtask

    typedef struct { bit irdy; bit req; logic [31:0] addr; bit ins; logic [31:0] pc; } vec_t;

    initial begin
        vec_t        st[6];
        vec_t        bp[15];
        bit          o_req, o_ins;
        logic [31:0] o_addr, o_pc;
        int          n, d0, pend;

        st[0] = '{1, 1, 32'h100, 0, 32'h0};
        st[1] = '{1, 1, 32'h104, 0, 32'h0};
        st[2] = '{1, 1, 32'h108, 1, 32'h100};
        st[3] = '{1, 1, 32'h10C, 1, 32'h104};
        st[4] = '{1, 1, 32'h110, 1, 32'h108};
        st[5] = '{1, 1, 32'h114, 1, 32'h10C};

        bp[0]  = '{0, 1, 32'h100, 0, 32'h0};
        bp[1]  = '{0, 1, 32'h104, 0, 32'h0};
        bp[2]  = '{0, 1, 32'h108, 1, 32'h100};
        bp[3]  = '{0, 1, 32'h10C, 1, 32'h100};
        for (int i = 4; i < 10; i++) bp[i] = '{0, 0, 32'h0, 1, 32'h100};
        bp[10] = '{1, 0, 32'h0,   1, 32'h100};
        bp[11] = '{1, 1, 32'h110, 1, 32'h104};
        bp[12] = '{1, 1, 32'h114, 1, 32'h108};
        bp[13] = '{1, 1, 32'h118, 1, 32'h10C};
        bp[14] = '{1, 1, 32'h11C, 1, 32'h110};

        // Streaming from reset, latency 1; the 64-bit instance checks PC wrap alongside.
        lat = 1;
        do_reset();
        r64 = 1'b1;
        #1;
        chk("w64_req_valid", v64, 1);
        chk("w64_addr0", a64, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 6; i++) begin
            tick(1, st[i].irdy, 0, 0, o_req, o_addr, o_ins, o_pc);
            if (i == 0) begin
                r64 = 1'b0;
                chk("w64_addr1", a64, 64'h0);
            end
            chk("st_req", o_req, st[i].req);
            if (st[i].req) chk("st_addr", o_addr, st[i].addr);
            chk("st_ins", o_ins, st[i].ins);
            if (st[i].ins) chk("st_pc", o_pc, st[i].pc);
        end

        // Decode stall for 10 cycles, then release.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick(1, bp[i].irdy, 0, 0, o_req, o_addr, o_ins, o_pc);
            chk("bp_req", o_req, bp[i].req);
            if (bp[i].req) chk("bp_addr", o_addr, bp[i].addr);
            chk("bp_ins", o_ins, bp[i].ins);
            if (bp[i].ins) chk("bp_pc", o_pc, bp[i].pc);
            if (i == 9) chk("bp_accepted", fires, 4);
        end

        // Redirect with three requests in flight, latency 3.
        lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) run(1, 1, 0, 0);
        d0 = drops;
        run(1, 1, 1, 32'h2002);
        tick(1, 1, 0, 0, o_req, o_addr, o_ins, o_pc);
        chk("rd_req_valid", o_req, 1);
        chk("rd_req_addr", o_addr, 32'h2000);
        n = 0;
        o_ins = 0;
        while (!o_ins && n < 20) begin
            tick(1, 0, 0, 0, o_req, o_addr, o_ins, o_pc);
            n++;
        end
        chk("rd_first_delay", n, 4);
        chk("rd_first_pc", o_pc, 32'h2000);
        chk("rd_dropped", drops - d0, 3);

        // Redirect in the same cycle as a response and a pop, latency 2.
        lat = 2;
        do_reset();
        n = 0;
        while (n < 30 && !(bufq.size() > 0 && memq.size() > 0 && memq[0].due <= cyc && n >= 4)) begin
            run(1, 1, 0, 0);
            n++;
        end
        chk("co_setup_bound", n < 30, 1);
        pend = memq.size() - 1;
        d0   = drops;
        run(1, 1, 1, 32'h3000);
        tick(1, 1, 0, 0, o_req, o_addr, o_ins, o_pc);
        chk("co_flushed", o_ins, 0);
        n = 0;
        o_ins = 0;
        while (!o_ins && n < 20) begin
            tick(1, 1, 0, 0, o_req, o_addr, o_ins, o_pc);
            n++;
        end
        chk("co_first_pc", o_pc, 32'h3000);
        chk("co_dropped", drops - d0, pend + 1);

        // Reset with a full buffer, then restart.
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) run(1, 0, 0, 0);
        chk("mr_full", ins_vld, 1);
        do_reset();
        tick(1, 1, 0, 0, o_req, o_addr, o_ins, o_pc);
        chk("mr_restart_valid", o_req, 1);
        chk("mr_restart_addr", o_addr, RV);

        // Random traffic, fresh latency per segment.
        for (int s = 0; s < 4; s++) begin
            lat = $urandom_range(1, 5);
            do_reset();
            for (int i = 0; i < 300; i++) begin
                run(($urandom % 4) != 0, ($urandom % 10) < 7, ($urandom % 25) == 0, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage that supersedes the bare PC/IR pair in the core datapath. Holds the program counter, issues sequential word fetches to instruction memory over a valid/ready request channel, and accepts in-order responses with latency of one or more cycles. Buffers fetched instructions with their PCs in a small FIFO toward decode. Supports redirect (branch/jump), which flushes the buffer and discards responses still in flight.

## Interface
- DATA_WIDTH, 32: PC/address width (32 or 64).
- BUFFER_DEPTH, 4: fetch buffer entries and maximum outstanding requests; power of two, ≥2.
- RESET_VECTOR, 0: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- fetch_unit_clock_in  in  1  sole clock; all state updates on the rising edge.
- fetch_unit_reset_in  in  1  synchronous, active-high reset.
- fetch_unit_mem_req_valid_out  out  1  fetch request valid.
- fetch_unit_mem_req_addr_out  out  DATA_WIDTH  fetch address; equals current PC.
- fetch_unit_mem_req_ready_in  in  1  memory accepts the request this cycle.
- fetch_unit_mem_rsp_valid_in  in  1  response word valid; in order, one per accepted request.
- fetch_unit_mem_rsp_data_in  in  32  instruction word.
- fetch_unit_redirect_valid_in  in  1  load a new PC and flush.
- fetch_unit_redirect_addr_in  in  DATA_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- fetch_unit_ins_valid_out  out  1  buffer head valid toward decode.
- fetch_unit_ins_data_out  out  32  head instruction; 0 when the buffer is empty.
- fetch_unit_ins_pc_out  out  DATA_WIDTH  head PC; 0 when the buffer is empty.
- fetch_unit_ins_ready_in  in  1  decode consumes the head this cycle.

## Operation
- State:
  - pc: next address to request.
  - rsp_pc: PC of the next non-dropped response.
  - outstanding: count of requests accepted but not yet responded to, 0..BUFFER_DEPTH.
  - drop: count of pending responses to discard.
  - FIFO of {pc, instruction} with count, read pointer and write pointer.
- Request:
  - mem_req_valid_out = !reset && !redirect_valid_in && (count + outstanding < BUFFER_DEPTH).
  - The combinational path from redirect_valid_in is intended.
  - Handshake is valid && ready. On handshake: pc += 4 (modulo 2^DATA_WIDTH wrap) and outstanding += 1.
- Response when rsp_valid: outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise: push {rsp_pc, data} and rsp_pc += 4.
- Pop on ins_valid && ins_ready.
- Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur by construction: every slot is reserved at request time.
- Redirect has priority over every other update in the same cycle:
  - pc and rsp_pc <= redirect_addr with bits [1:0] = 0.
  - The FIFO is emptied; the pop is ignored.
  - A response arriving in this cycle is discarded.
  - drop <= outstanding − rsp_valid (in-flight responses still to come).
  - outstanding <= outstanding − rsp_valid.
  - No request is issued.
- Back-to-back redirects: the last one wins. The drop count is recomputed each time, so no stale word is ever delivered.
- Reset (any cycle, including mid-transaction):
  - pc = rsp_pc = RESET_VECTOR.
  - outstanding, drop and count = 0.
  - All outputs 0.
  - The environment must also reset memory, since responses that arrive after reset are not tracked.

## Timing
- First request is visible in the first cycle after reset deasserts, with addr = RESET_VECTOR.
- Issue rate: up to one request per cycle. The stream sustains full throughput when memory latency is less than BUFFER_DEPTH cycles.
- Response in cycle N appears at ins_valid_out in cycle N+1; there is no bypass.
- Decode stall (ins_ready low) fills the buffer, after which req_valid drops. Issue resumes the cycle after a pop frees a slot.
- Redirect in cycle N:
  - Cycle N+1: req_valid = 1 with addr = target.
  - Earliest delivery of the target instruction is cycle N+1 + latency + 1.
- Outputs toward decode and memory are registered state, except req_valid's dependence on redirect_valid_in.

## Test plan
- Reset streaming: RESET_VECTOR=0x100, memory latency 1, ready always high, decode always ready. Required: addresses 0x100, 0x104, 0x108… on consecutive cycles; instructions delivered in order with matching ins_pc, one per cycle after fill.
- Backpressure: decode ready held low for 10 cycles, BUFFER_DEPTH=4. Required: exactly 4 requests accepted and 4 words buffered, then req_valid = 0. On release, words are delivered in order and each pop re-enables exactly one request.
- Redirect with 3 in flight: latency 3, redirect to 0x2002 while 3 requests are outstanding. Required: 3 subsequent responses dropped; next request addr = 0x2000; first delivered ins_pc = 0x2000; no stale word appears.
- Redirect coincident with a response and a pop: required count = 0, the word is discarded, and drop = outstanding − 1.
- Wrap and width: DATA_WIDTH=64, RESET_VECTOR=0xFFFF_FFFF_FFFF_FFFC. Required: second address = 0x0.
- Mid-operation reset with a full buffer: required all outputs 0 the next cycle, then a restart at RESET_VECTOR.
